// File: rtl/adder_pkg.sv
// Shared types and default sizing for the integer-unit adder scheduler.
package adder_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REQ_NUMBER = 4;
    localparam int unsigned ID_WIDTH   = $clog2(REQ_NUMBER);

    typedef logic [ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] operand_A;
        logic [DATA_WIDTH-1:0] operand_B;
        logic                  carry;
    } add_req_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Combinational adder built from generate/propagate terms; WIDTH-bit sum plus carry-out.
module carry_lookahead_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Carry into bit i+1 is generated at i or propagated through i.
    always_comb begin
        carry    = '0;
        carry[0] = carry_i;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum_o   = prop ^ carry[WIDTH-1:0];
    assign carry_o = carry[WIDTH];

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from priority_ptr.
module round_robin_arbiter #(
    parameter int unsigned REQ_NUMBER = adder_pkg::REQ_NUMBER,
    parameter int unsigned ID_WIDTH   = $clog2(REQ_NUMBER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REQ_NUMBER-1:0] request,
    input  logic                  advance,
    output logic [REQ_NUMBER-1:0] grant,
    output logic [ID_WIDTH-1:0]   grant_id
);

    logic [ID_WIDTH-1:0] priority_ptr;
    int unsigned         idx;
    logic                found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < REQ_NUMBER; i++) begin
            idx = 32'(priority_ptr) + i;
            if (idx >= REQ_NUMBER) begin
                idx = idx - REQ_NUMBER;
            end
            if (!found && request[ID_WIDTH'(idx)]) begin
                grant[ID_WIDTH'(idx)] = 1'b1;
                grant_id              = ID_WIDTH'(idx);
                found                 = 1'b1;
            end
        end
    end

    // Pointer moves only when a grant is actually taken, to one past the winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            priority_ptr <= '0;
        end else if (advance) begin
            if (32'(grant_id) == REQ_NUMBER - 1) begin
                priority_ptr <= '0;
            end else begin
                priority_ptr <= grant_id + ID_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one adder between REQ_NUMBER requesters with round-robin arbitration
// and a single registered, ID-tagged output stage.
module adder_scheduler #(
    parameter int unsigned DATA_WIDTH = adder_pkg::DATA_WIDTH,
    parameter int unsigned REQ_NUMBER = adder_pkg::REQ_NUMBER,
    parameter int unsigned ID_WIDTH   = $clog2(REQ_NUMBER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REQ_NUMBER-1:0] req_valid_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i [REQ_NUMBER],
    input  logic [DATA_WIDTH-1:0] operand_B_i [REQ_NUMBER],
    input  logic [REQ_NUMBER-1:0] carry_i,
    output logic [REQ_NUMBER-1:0] req_ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic [ID_WIDTH-1:0]   req_id_o,
    input  logic                  ready_i
);

    import adder_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] operand_A;
        logic [DATA_WIDTH-1:0] operand_B;
        logic                  carry;
    } sel_req_t;

    logic [REQ_NUMBER-1:0] grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  stage_free;
    logic                  accept;
    logic                  advance;
    sel_req_t              sel;
    logic [DATA_WIDTH-1:0] sum;
    logic                  sum_carry;

    assign stage_free = ~valid_o | ready_i;
    assign advance    = stage_free & (|req_valid_i);
    assign accept     = stage_free & (|grant) & ~rst_i;

    round_robin_arbiter #(
        .REQ_NUMBER (REQ_NUMBER),
        .ID_WIDTH   (ID_WIDTH)
    ) u_arbiter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .request  (req_valid_i),
        .advance  (advance),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready_o = grant & {REQ_NUMBER{stage_free & ~rst_i}};

    // Operand mux in front of the single shared adder.
    always_comb begin
        sel.operand_A = operand_A_i[grant_id];
        sel.operand_B = operand_B_i[grant_id];
        sel.carry     = carry_i[grant_id];
    end

    carry_lookahead_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_adder (
        .a_i     (sel.operand_A),
        .b_i     (sel.operand_B),
        .carry_i (sel.carry),
        .sum_o   (sum),
        .carry_o (sum_carry)
    );

    // Output stage: load on accept, drop valid on a drain with nothing new, else hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            carry_o  <= 1'b0;
            req_id_o <= '0;
        end else if (accept) begin
            valid_o  <= 1'b1;
            result_o <= sum;
            carry_o  <= sum_carry;
            req_id_o <= grant_id;
        end else if (ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler: reset, single request, full load,
// backpressure, pointer rotation and mid-operation reset.
module tb_adder_scheduler;

    import adder_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned RN = 4;

    logic          clk;
    logic          rst;
    logic [RN-1:0] req_valid;
    logic [DW-1:0] op_a [RN];
    logic [DW-1:0] op_b [RN];
    logic [RN-1:0] cin;
    logic [RN-1:0] req_ready;
    logic          valid;
    logic [DW-1:0] result;
    logic          cout;
    req_id_t       req_id;
    logic          ready;

    add_req_t      reqs [RN];

    int unsigned   n_checks;
    int unsigned   n_pass;

    always_comb begin
        for (int k = 0; k < int'(RN); k++) begin
            op_a[k] = reqs[k].operand_A;
            op_b[k] = reqs[k].operand_B;
            cin[k]  = reqs[k].carry;
        end
    end

    adder_scheduler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .operand_A_i (op_a),
        .operand_B_i (op_b),
        .carry_i     (cin),
        .req_ready_o (req_ready),
        .valid_o     (valid),
        .result_o    (result),
        .carry_o     (cout),
        .req_id_o    (req_id),
        .ready_i     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
        reqs[k].operand_A = a;
        reqs[k].operand_B = b;
        reqs[k].carry     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the output stage against a hand-computed 33-bit sum and tag.
    task automatic check_out(input string tag, input logic [1:0] id, input logic [32:0] exp_sum);
        check({tag, "_valid"}, 64'(valid), 64'(1));
        check({tag, "_id"}, 64'(req_id), 64'(id));
        check({tag, "_result"}, 64'(result), 64'(exp_sum[31:0]));
        check({tag, "_carry"}, 64'(cout), 64'(exp_sum[32]));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        ready     = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < int'(RN); k++) begin
            set_req(k, 32'(k), 32'h10, 1'b1);
        end

        // Reset held for two cycles with every requester valid.
        tick();
        check("rst_ready_c0", 64'(req_ready), 64'(0));
        tick();
        check("rst_ready_c1", 64'(req_ready), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_carry", 64'(cout), 64'(0));
        check("rst_id", 64'(req_id), 64'(0));

        rst = 1'b0;
        #1;
        check("first_grant", 64'(req_ready), 64'(4'b0001));

        // Full load: ids 0,1,2,3,0,1 with 0x11+k and no bubbles.
        for (int j = 0; j < 6; j++) begin
            tick();
            check_out($sformatf("full%0d", j), 2'(j % 4), 33'(32'h11 + 32'(j % 4)));
        end

        // Backpressure with requesters 2 and 3 valid; output holds id1 / 0x12.
        ready     = 1'b0;
        req_valid = 4'b1100;
        set_req(2, 32'h0000_1000, 32'h0000_0234, 1'b0);
        set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        #1;
        check("bp_ready_init", 64'(req_ready), 64'(0));
        for (int j = 0; j < 3; j++) begin
            tick();
            check_out($sformatf("bp_hold%0d", j), 2'd1, 33'h0_0000_0012);
            check($sformatf("bp_ready%0d", j), 64'(req_ready), 64'(0));
        end
        ready = 1'b1;
        #1;
        check("bp_release", 64'(req_ready), 64'(4'b0100));
        tick();
        check_out("bp_new", 2'd2, 33'h0_0000_1234);

        // Rotation: after 2, only 0 and 3 valid -> 3 then 0.
        req_valid = 4'b1001;
        set_req(0, 32'h0000_0005, 32'h0000_0007, 1'b0);
        #1;
        check("rot_grant3", 64'(req_ready), 64'(4'b1000));
        tick();
        check_out("rot_out3", 2'd3, 33'h1_FFFF_FFFF);
        check("rot_grant0", 64'(req_ready), 64'(4'b0001));
        tick();
        check_out("rot_out0", 2'd0, 33'h0_0000_000C);
        check("rot_grant3b", 64'(req_ready), 64'(4'b1000));

        // Move pointer to 3 via a lone request from 2.
        req_valid = 4'b0100;
        set_req(2, 32'h0000_0001, 32'h0000_0002, 1'b0);
        #1;
        check("pre_rst_grant2", 64'(req_ready), 64'(4'b0100));
        tick();
        check_out("pre_rst_out2", 2'd2, 33'h0_0000_0003);

        // Reset mid-operation with result held and pointer at 3.
        rst       = 1'b1;
        req_valid = 4'b1011;
        set_req(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        #1;
        check("midrst_ready", 64'(req_ready), 64'(0));
        tick();
        check("midrst_valid", 64'(valid), 64'(0));
        check("midrst_id", 64'(req_id), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("postrst_grant1", 64'(req_ready), 64'(4'b0010));
        tick();
        check_out("postrst_out1", 2'd1, 33'h1_0000_0000);

        // Single request from 1: 0xFFFF_FFFF + 1 wraps with carry-out.
        req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        #1;
        check("single_grant1", 64'(req_ready), 64'(4'b0010));
        tick();
        check_out("single_out1", 2'd1, 33'h1_0000_0000);

        // Drain with no new request: valid drops, data holds.
        req_valid = 4'b0000;
        tick();
        check("drain_valid", 64'(valid), 64'(0));
        check("drain_result", 64'(result), 64'(0));
        check("drain_id", 64'(req_id), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Shares one `DATA_WIDTH`-bit adder core between `REQ_NUMBER` requesters in the integer execution unit.
- Arbitration is round-robin.
- Each requester has a valid/ready handshake.
- The result goes through one registered output stage, tagged with the requester ID.
- A single downstream consumer drains the output through a valid/ready handshake.
- Throughput is one addition per cycle when the consumer is not stalling.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: operand and result width.
- `REQ_NUMBER`, default 4: number of requesters, ≥2.
- `ID_WIDTH`, default $clog2(`REQ_NUMBER`): requester tag width.

Ports:
- `clk_i` input 1: single clock. All state updates on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `req_valid_i[REQ_NUMBER]` input 1 each: requester holds operands valid.
- `operand_A_i[REQ_NUMBER]` input `DATA_WIDTH` each: addend A.
- `operand_B_i[REQ_NUMBER]` input `DATA_WIDTH` each: addend B.
- `carry_i[REQ_NUMBER]` input 1 each: carry-in.
- `req_ready_o[REQ_NUMBER]` output 1 each: the request is accepted this cycle.
- `valid_o` output 1: the output register holds a result.
- `result_o` output `DATA_WIDTH`: sum.
- `carry_o` output 1: carry-out.
- `req_id_o` output `ID_WIDTH`: index of the requester that produced the result.
- `ready_i` input 1: the consumer accepts the result this cycle.

## Operation

- `stage_free = ~valid_o | ready_i`. The output register is empty, or it is being drained this cycle.
- Grant is combinational: the first asserted `req_valid_i[k]`, scanning from `priority_ptr` upward, modulo `REQ_NUMBER`.
- `req_ready_o[k] = grant[k] & stage_free & ~rst_i`. At most one ready bit is high in any cycle.
- The selected operands feed the single adder instance: `{carry, result} = A + B + carry_in`. The sum is (`DATA_WIDTH`+1) bits and wraps modulo 2^(`DATA_WIDTH`+1); there is no overflow flag.
- On acceptance (any `req_ready_o[k]` high):
  - `result_o`, `carry_o` and `req_id_o <= k` load.
  - `valid_o <= 1`.
  - `priority_ptr <= (k+1) mod REQ_NUMBER`.
- Drain without a new accept (`valid_o & ready_i` and no grant): `valid_o <= 0`. Data registers hold their last value.
- Stall (`valid_o & ~ready_i`):
  - All outputs hold.
  - All `req_ready_o` are 0.
  - `priority_ptr` holds.
- The pointer never moves without an acceptance. A requester that drops `req_valid_i` before being accepted loses nothing and is not charged a turn.
- Fairness: a continuously valid requester is accepted within `REQ_NUMBER` accepts.
- A requester must hold its operands stable while `req_valid_i` is high and ready is low. The block does not check this.

## Timing

- Latency: accept in cycle N gives `valid_o` = 1 with data in cycle N+1.
- Back-to-back: drain and accept in the same cycle is legal and required, so there are no bubbles.
- Reset, applied at the rising edge while `rst_i` = 1:
  - `valid_o` = 0, `result_o` = 0, `carry_o` = 0, `req_id_o` = 0.
  - `priority_ptr` = 0, so requester 0 has highest priority.
  - `req_ready_o` = 0 throughout reset.
- Reset mid-operation discards any held result and any in-flight grant. The first accept after reset follows the ptr=0 order.
- Requests that are simultaneous with the drain are arbitrated normally. Requests during a stall are all held off.

## Structure

- Shared package `adder_pkg`:
  - `DATA_WIDTH`, `REQ_NUMBER`.
  - `req_id_t` (logic [`ID_WIDTH`-1:0]).
  - struct `add_req_t` {operand_A, operand_B, carry}.
- Sub-module `round_robin_arbiter`:
  - Inputs: `clk_i`, `rst_i`, `request[REQ_NUMBER]`, `advance`.
  - Outputs: one-hot `grant`, `grant_id`.
  - It owns `priority_ptr`.
  - The scheduler drives `advance = stage_free & |request`.
- The adder core is the existing `carry_lookahead_adder`, instantiated once. The output stage and handshake live in `adder_scheduler`.

## Test plan

- Reset:
  - Hold `rst_i` for 2 cycles with all `req_valid_i` = 1. All `req_ready_o` = 0 during reset.
  - Afterwards `valid_o` = 0, `result_o` = 0, `req_id_o` = 0.
  - The first grant goes to requester 0.
- Single request: requester 1 with A=0xFFFF_FFFF, B=0x0000_0001, cin=0, `ready_i` = 1.
  - `req_ready_o[1]` = 1 in cycle N.
  - Cycle N+1: `valid_o` = 1, `result_o` = 0x0000_0000, `carry_o` = 1, `req_id_o` = 1.
- Full load: all 4 requesters are continuously valid with A=k, B=0x10, cin=1, and `ready_i` = 1.
  - `req_id_o` sequence is 0,1,2,3,0,1 on consecutive cycles.
  - `result_o` = 0x11+k each time, with no idle cycles.
- Backpressure: `valid_o` = 1, `ready_i` = 0 for 3 cycles, with requesters 2 and 3 valid.
  - Outputs are stable and all `req_ready_o` = 0.
  - In the cycle `ready_i` rises, requester 2 is accepted (ptr was 2). The new result appears in the next cycle.
- Pointer rotation: after a grant to requester 2, only requesters 0 and 3 are valid. Requester 3 is granted first, then 0.
- Reset mid-operation: assert `rst_i` while `valid_o` = 1 and `priority_ptr` = 3.
  - Next cycle `valid_o` = 0.
  - The next accept goes to the lowest-index valid requester.
  - Compare every accepted result against the `A + B + cin` golden model.
